// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle radix-2 restoring integer divider (signed/unsigned)
//
// Purpose: computes quotient and remainder of in_dividend / in_divisor, one
// restoring step per clock, MSB first. Division truncates toward zero and the
// remainder takes the dividend's sign. Divide-by-zero gives quotient all-ones
// and remainder equal to the raw dividend, flagged by out_dbz.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, an op whose |dividend| < |divisor| (divisor nonzero) skips
//   the iteration phase; the result is valid two edges after accept.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   flush                cancel the in-flight op and any pending result
//   in_valid/in_ready    request handshake; in_ready is low during flush
//   in_signed            1 = signed operands, 0 = unsigned
//   in_dividend          dividend (WIDTH)
//   in_divisor           divisor (WIDTH)
//   in_tag               sideband tag carried to out_tag (TAG_W)
//   out_valid/out_ready  result handshake; outputs held while out_ready is low
//   out_quot, out_rem    quotient and remainder (WIDTH)
//   out_tag              tag of the result
//   out_dbz              divisor was zero
//   busy                 unit is not idle

module iter_divider #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // a_r starts as the dividend magnitude; quotient bits shift in at the LSB
    // as dividend bits shift out at the MSB, so it ends holding the quotient.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] raw_r;
    logic [TAG_W-1:0] tag_r;
    logic             qs_r;
    logic             rs_r;
    logic             dbz_r;

    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic             fix_go;

`ifdef DIV_EARLY_OUT_EN
    logic             early;
    // Holds FIX for one extra cycle on the early-out path so the operand
    // latch and the result register stay in separate cycles.
    logic             early_hold;
`endif

    assign in_ready = (state == IDLE) & ~flush;
    assign busy     = (state != IDLE);

    always_comb begin
        sa    = in_signed & in_dividend[WIDTH-1];
        sb    = in_signed & in_divisor[WIDTH-1];
        // Negating MIN yields MIN, which read unsigned is exactly 2^(WIDTH-1).
        mag_a = sa ? (-in_dividend) : in_dividend;
        mag_b = sb ? (-in_divisor) : in_divisor;

        // Partial remainder is always < divisor, so after the shift it is
        // < 2*divisor and the difference fits in WIDTH bits when no borrow.
        shifted = {rem_r, a_r[WIDTH-1]};
        diff    = shifted - {1'b0, b_r};
        ge      = ~diff[WIDTH];

        fix_q = qs_r ? (-a_r) : a_r;
        fix_r = rs_r ? (-rem_r) : rem_r;
        if (dbz_r) begin
            fix_q = '1;
            fix_r = raw_r;
        end

`ifdef DIV_EARLY_OUT_EN
        early  = (in_divisor != '0) && (mag_a < mag_b);
        fix_go = ~early_hold;
`else
        fix_go = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            rem_r     <= '0;
            raw_r     <= '0;
            tag_r     <= '0;
            qs_r      <= 1'b0;
            rs_r      <= 1'b0;
            dbz_r     <= 1'b0;
            out_valid <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_tag   <= '0;
            out_dbz   <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            early_hold <= 1'b0;
`endif
        end else if (flush) begin
            // Result registers keep stale data; only the valid/dbz flags drop.
            state     <= IDLE;
            out_valid <= 1'b0;
            out_dbz   <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            early_hold <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= mag_a;
                        b_r   <= mag_b;
                        rem_r <= '0;
                        cnt   <= '0;
                        raw_r <= in_dividend;
                        tag_r <= in_tag;
                        qs_r  <= sa ^ sb;
                        rs_r  <= sa;
                        dbz_r <= (in_divisor == '0);
                        state <= CALC;
`ifdef DIV_EARLY_OUT_EN
                        // Quotient 0 and remainder |dividend|; re-applying the
                        // dividend sign in FIX restores the raw dividend.
                        if (early) begin
                            a_r        <= '0;
                            rem_r      <= mag_a;
                            early_hold <= 1'b1;
                            state      <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    rem_r <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    a_r   <= {a_r[WIDTH-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
`ifdef DIV_EARLY_OUT_EN
                    early_hold <= 1'b0;
`endif
                    if (fix_go) begin
                        out_quot  <= fix_q;
                        out_rem   <= fix_r;
                        out_tag   <= tag_r;
                        out_dbz   <= dbz_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - table-driven self-checking bench for iter_divider

module tb_iter_divider;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             resetn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    logic [TAG_W-1:0] out_tag;
    logic             out_dbz;
    logic             busy;

    iter_divider #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .out_tag     (out_tag),
        .out_dbz     (out_dbz),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        early;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic early);
`ifdef DIV_EARLY_OUT_EN
        return early ? 2 : WIDTH + 1;
`else
        return (early === 1'bx) ? 0 : WIDTH + 1;
`endif
    endfunction

    // Issue one op, measure edges from accept to out_valid, check the result,
    // hold out_ready low for 'hold' cycles, then complete the handshake.
    task automatic run_op(input vec_t v, input int hold);
        int n;
        @(negedge clk);
        in_signed   = v.sgn;
        in_dividend = v.a;
        in_divisor  = v.b;
        in_tag      = v.tag;
        in_valid    = 1'b1;
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 100);
        check("latency", n, exp_lat(v.early));
        check("quot", out_quot, v.q);
        check("rem", out_rem, v.r);
        check("tag", {27'b0, out_tag}, {27'b0, v.tag});
        check("dbz", {31'b0, out_dbz}, {31'b0, v.dbz});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_quot", out_quot, v.q);
            check("hold_rem", out_rem, v.r);
            check("hold_tag", {27'b0, out_tag}, {27'b0, v.tag});
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", {31'b0, out_valid}, 32'd0);
        check("post_hs_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        vec_t bp;

        vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'h00000010, 5'd3,  32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 5'd5,  32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, 32'h00000000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 32'hFFFFFFFB, 32'h00000000, 5'd7,  32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 32'h00000005, 32'h00000000, 5'd8,  32'hFFFFFFFF, 32'h00000005, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h00000003, 32'h0000000A, 5'd9,  32'h00000000, 32'h00000003, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000000A, 32'h00000003, 5'd10, 32'h00000003, 32'h00000001, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'h00000007, 5'd11, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 32'h80000000, 32'h80000000, 5'd12, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd13, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'hFFFFFFFD, 32'h0000000A, 5'd31, 32'h00000000, 32'hFFFFFFFD, 1'b0, 1'b1};

        resetn      = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_quot", out_quot, 32'd0);
        check("rst_rem", out_rem, 32'd0);
        check("rst_tag", {27'b0, out_tag}, 32'd0);
        check("rst_dbz", {31'b0, out_dbz}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], 0);
        end

        // Backpressure for 10 cycles, then an immediate back-to-back op.
        bp = '{1'b0, 32'h00001234, 32'h00000010, 5'd17, 32'h00000123, 32'h00000004, 1'b0, 1'b0};
        run_op(bp, 10);
        run_op(vecs[1], 0);

        // Flush at iteration 12.
        @(negedge clk);
        in_signed   = 1'b0;
        in_dividend = 32'hFFFFFFFF;
        in_divisor  = 32'h00000003;
        in_tag      = 5'd21;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_dbz", {31'b0, out_dbz}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", seen, 0);

        // Flush concurrent with in_valid in IDLE must not accept.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_no_accept", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check("flush_accept_idle", seen, 0);

        // Reset asserted mid-CALC clears outputs without a clock edge.
        @(negedge clk);
        in_signed   = 1'b1;
        in_dividend = 32'hFFFFFFF9;
        in_divisor  = 32'h00000002;
        in_tag      = 5'd9;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_valid", {31'b0, out_valid}, 32'd0);
        check("arst_quot", out_quot, 32'd0);
        check("arst_rem", out_rem, 32'd0);
        check("arst_tag", {27'b0, out_tag}, 32'd0);
        check("arst_dbz", {31'b0, out_dbz}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(vecs[7], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
